// File: rtl/cxl_arb_pkg.sv
// Shared definitions for the CXL memory AXI arbiter.
//   - default widths and timeout for the arbiter parameters
//   - FSM state encoding (also visible on the debug state output)
//   - requester indices: REQ_FILL = DRAM-cache miss fill, REQ_WB = dirty writeback
//   - idx_to_onehot(): requester index to 2-bit one-hot vector
package cxl_arb_pkg;

    localparam int ADDR_W_DEF  = 64;
    localparam int DATA_W_DEF  = 512;
    localparam int TAG_W_DEF   = 64;
    localparam int ID_W_DEF    = 16;
    localparam int TIMEOUT_DEF = 1024;
    localparam int NUM_REQ     = 2;

    localparam logic REQ_FILL = 1'b0;
    localparam logic REQ_WB   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_i        request vector (bit per requester)
//   upd_i        strobe: record upd_idx_i as the last granted requester
//   upd_idx_i    index of the requester just served
//   gnt_o        one-hot grant (zero when nobody requests)
//   gnt_idx_o    index of the winner (meaningful only when req_i != 0)
// On contention the requester not granted last wins. last-grant resets to
// REQ_WB so REQ_FILL wins the first tie after reset.
module rr_arb2
    import cxl_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               upd_i,
    input  logic               upd_idx_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_idx_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_idx_o = REQ_FILL;
        if (req_i[REQ_FILL] && req_i[REQ_WB]) begin
            gnt_idx_o = ~last_q;
        end else if (req_i[REQ_WB]) begin
            gnt_idx_o = REQ_WB;
        end
        gnt_o = (|req_i) ? idx_to_onehot(gnt_idx_o) : '0;
    end

    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            last_d = upd_idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_WB;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cxl_axi_arbiter.sv
// Shares one CXL memory AXI slave port between the miss-fill requester (0)
// and the writeback requester (1). One 64-byte line transaction at a time.
// Ports:
//   req_valid/req_ready/req_we/req_addr/req_wdata  per-requester request (packed, requester i at slice i)
//   rsp_valid/rsp_we/rsp_rdata                     response pulse, type echo, {tag,data} of last read
//   err                                             sticky handshake-timeout flag
//   ar*/r*/aw*/w*/b*                                AXI master channels
//   dbg_state_o                                     current FSM state
// Handshake rule: a request/response/AXI transfer happens on a rising edge
// where valid and ready are both high; a raised valid is held, with stable
// payload, until that edge. All valids here are state decodes; only req_ready
// looks at req_valid, and only in IDLE.
module cxl_axi_arbiter
    import cxl_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_we,
    output logic [TAG_W+DATA_W-1:0]   rsp_rdata,
    output logic                      err,
    output logic [ID_W-1:0]           arid_o,
    output logic [ADDR_W-1:0]         araddr_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    input  logic [ID_W-1:0]           rid_i,
    input  logic [TAG_W+DATA_W-1:0]   rdata_i,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    output logic [ID_W-1:0]           awid_o,
    output logic [ADDR_W-1:0]         awaddr_o,
    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [ID_W-1:0]           wid_o,
    output logic [DATA_W-1:0]         wdata_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    input  logic [ID_W-1:0]           bid_i,
    input  logic                      bvalid_i,
    output logic                      bready_o,
    output logic [2:0]                dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_e                state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic                      gidx_q, gidx_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [TAG_W+DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;

    logic [NUM_REQ-1:0]        gnt;
    logic                      gnt_idx;
    logic                      aw_hs, w_hs, waiting;

    // IDs are not needed for routing with a single outstanding transaction.
    logic                      unused_ids;
    assign unused_ids = ^{rid_i, bid_i};

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .upd_i     (state_q == ST_RESP),
        .upd_idx_i (gidx_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign aw_hs   = awvalid_o && awready_i;
    assign w_hs    = wvalid_o && wready_i;
    assign waiting = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA) ||
                     (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        gidx_d    = gidx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        cnt_d     = '0;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    gidx_d    = gnt_idx;
                    we_d      = req_we[gnt_idx];
                    addr_d    = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
                    wdata_d   = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we[gnt_idx] ? ST_WR_REQ : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (arready_i) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (rvalid_i) begin
                    rdata_d = rdata_i;
                    state_d = ST_RESP;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; leave once both are done.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (bvalid_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cycles spent waiting in the current state; saturates at the limit.
        if (waiting && (state_d == state_q)) begin
            cnt_d = (cnt_q == CNT_W'(TIMEOUT_CYC)) ? cnt_q : cnt_q + 1'b1;
        end
        if (waiting && (cnt_d == CNT_W'(TIMEOUT_CYC))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            gidx_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            gidx_q    <= gidx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE) ? gnt : '0;

    assign arvalid_o   = (state_q == ST_RD_ADDR);
    assign araddr_o    = addr_q;
    assign arid_o      = ID_W'(gidx_q);
    assign rready_o    = (state_q == ST_RD_DATA);

    assign awvalid_o   = (state_q == ST_WR_REQ) && !aw_done_q;
    assign awaddr_o    = addr_q;
    assign awid_o      = ID_W'(gidx_q);
    assign wvalid_o    = (state_q == ST_WR_REQ) && !w_done_q;
    assign wdata_o     = wdata_q;
    assign wid_o       = ID_W'(gidx_q);
    assign bready_o    = (state_q == ST_WR_RESP);

    assign rsp_valid   = (state_q == ST_RESP) ? idx_to_onehot(gidx_q) : '0;
    assign rsp_we      = we_q;
    assign rsp_rdata   = rdata_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/cxl_axi_arbiter.md
# cxl_axi_arbiter

Two-requester scheduler that shares the single CXL memory AXI slave port between the DRAM-cache miss-fill path (requester 0) and the dirty-eviction writeback path (requester 1). It accepts one 64-byte line request at a time, drives the AXI AR/R or AW/W/B sequence, and returns read data (tag + line) or a write acknowledgement to the granted requester. Only one transaction is outstanding at any time; grants alternate round-robin on contention.

## Interface
Parameters:
- ADDR_W, 64, AXI/request address width
- DATA_W, 512, line data width
- TAG_W, 64, tag field prepended to read data (rdata = {tag, data})
- ID_W, 16, AXI ID width
- TIMEOUT_CYC, 1024, cycles waiting on a single slave handshake before the error flag is set

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req_we  in  2  1 = write, 0 = read, per requester
- req_addr  in  2×ADDR_W  per-requester line address
- req_wdata  in  2×DATA_W  per-requester write data
- rsp_valid  out  2  one-cycle response pulse to granted requester
- rsp_we  out  1  echo of the completed transaction type
- rsp_rdata  out  TAG_W+DATA_W  read data, held from capture until next read capture
- err  out  1  sticky timeout flag, cleared only by reset
- arid_o/araddr_o/arvalid_o/arready_i, rid_i/rdata_i/rvalid_i/rready_o: AXI read channels, rdata_i is TAG_W+DATA_W
- awid_o/awaddr_o/awvalid_o/awready_i, wid_o/wdata_o/wvalid_o/wready_i, bid_i/bvalid_i/bready_o: AXI write channels

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: if any req_valid, grant g = round-robin winner (alone → that one; both → the one not granted last). req_ready[g]=1 this cycle; latch addr, we, wdata, g. Next: RD_ADDR if read, WR_REQ if write.
- RD_ADDR: arvalid_o=1, araddr_o=latched addr, arid_o=g. On arready_i → RD_DATA.
- RD_DATA: rready_o=1. On rvalid_i capture rdata_i into rsp_rdata → RESP.
- WR_REQ: awvalid_o and wvalid_o asserted together; each drops independently after its own handshake (aw_done/w_done flags). awid_o=wid_o=g. When both done (same or different cycles) → WR_RESP.
- WR_RESP: bready_o=1. On bvalid_i → RESP.
- RESP: rsp_valid[g]=1, rsp_we=latched we; update last-grant to g → IDLE.
- rid_i/bid_i are not checked; single outstanding transaction makes routing unambiguous.
- Timeout: counter clears on every state change, increments in RD_ADDR/RD_DATA/WR_REQ/WR_RESP; at TIMEOUT_CYC set err; transaction keeps waiting.

## Timing
- Reset values: all valid/ready outputs 0, rsp_rdata 0, err 0, state IDLE, last-grant = 1 (requester 0 wins first tie), timeout counter 0.
- Reset asserted mid-transaction: immediate return to IDLE, all AXI valids drop asynchronously; in-flight transaction abandoned, no rsp_valid.
- AXI valid outputs and rsp_valid are pure state decodes (no input-to-output combinational path). req_ready depends combinationally on req_valid in IDLE only.
- Minimum latency, zero-wait slave: request accept cycle 0, arvalid cycle 1, rsp_valid cycle 3 (read), write same.
- Back-to-back: a requester held valid through RESP is re-arbitrated in the following IDLE cycle; at least one IDLE cycle between transactions.
- Valid outputs never deassert before their handshake (AXI-compliant hold); addr/data stable while valid.

## Structure
- Package cxl_arb_pkg: width constants, state enum, requester index constants (REQ_FILL=0, REQ_WB=1).
- Sub-module rr_arb2: 2-way round-robin grant with last-grant register updated by a strobe in RESP.

## Test plan
- Single read from req 0, addr 0x0000_0000_0000_0040, slave returns {tag 0xA5.., data 0x11..} → arid 0, araddr 0x40, rsp_valid[0] one cycle, rsp_rdata matches.
- Single write from req 1, addr 0x80, wdata 0xDEAD.. ; slave asserts awready two cycles before wready → awvalid drops first, wvalid held, rsp_valid[1] with rsp_we=1 after bvalid.
- Both requesters valid in same cycle from reset → req 0 granted first, req 1 next; repeat continuous contention → grants alternate 0,1,0,1.
- Write to 0x100 then read from 0x100 via slave memory model → read data equals written 0xCAFE.. pattern.
- Slave never asserts arready, TIMEOUT_CYC=16 → err rises at cycle 16 of RD_ADDR, arvalid stays high; rst_n pulse → err 0, arvalid 0, state IDLE.
